// File: rtl/sub16_serial.sv
// Bit-serial subtractor: diff = a - b, one full-subtractor step per clock, LSB first.
// Operands and results move over valid/ready handshakes; flags follow Hack ALU semantics.
module sub16_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zr,
  output logic             ng
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_bw;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_zr;
  logic             r_ng;

  logic [WIDTH-1:0] w_sa_nxt;
  logic [WIDTH-1:0] w_sb_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_bw_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_diff_nxt;
  logic             w_borrow_nxt;
  logic             w_zr_nxt;
  logic             w_ng_nxt;
  logic [1:0]       w_fs;
  logic [WIDTH-1:0] w_res_shift;

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic d;
    logic bout;
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
    return {bout, d};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, serial datapath step and completion capture.
  always_comb begin
    w_fs            = full_sub(r_sa[0], r_sb[0], r_bw);
    w_res_shift     = {w_fs[0], r_res[WIDTH-1:1]};
    w_state_nxt     = r_state;
    w_sa_nxt        = r_sa;
    w_sb_nxt        = r_sb;
    w_res_nxt       = r_res;
    w_bw_nxt        = r_bw;
    w_cnt_nxt       = r_cnt;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_diff_nxt      = r_diff;
    w_borrow_nxt    = r_borrow;
    w_zr_nxt        = r_zr;
    w_ng_nxt        = r_ng;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_sa_nxt       = a;
          w_sb_nxt       = b;
          w_bw_nxt       = 1'b0;
          w_cnt_nxt      = {CW{1'b0}};
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = ST_RUN;
        end else begin
          w_in_ready_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        w_sa_nxt  = {1'b0, r_sa[WIDTH-1:1]};
        w_sb_nxt  = {1'b0, r_sb[WIDTH-1:1]};
        w_res_nxt = w_res_shift;
        w_bw_nxt  = w_fs[1];
        w_cnt_nxt = r_cnt + CNT_ONE;
        // The last bit lands this edge, so publish the assembled word directly.
        if (r_cnt == LAST_CNT) begin
          w_diff_nxt      = w_res_shift;
          w_borrow_nxt    = w_fs[1];
          w_zr_nxt        = (w_res_shift == {WIDTH{1'b0}});
          w_ng_nxt        = w_fs[0];
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_out_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa        <= {WIDTH{1'b0}};
      r_sb        <= {WIDTH{1'b0}};
      r_res       <= {WIDTH{1'b0}};
      r_bw        <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_diff      <= {WIDTH{1'b0}};
      r_borrow    <= 1'b0;
      r_zr        <= 1'b1;
      r_ng        <= 1'b0;
    end else begin
      r_sa        <= w_sa_nxt;
      r_sb        <= w_sb_nxt;
      r_res       <= w_res_nxt;
      r_bw        <= w_bw_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_diff      <= w_diff_nxt;
      r_borrow    <= w_borrow_nxt;
      r_zr        <= w_zr_nxt;
      r_ng        <= w_ng_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign zr        = r_zr;
  assign ng        = r_ng;

endmodule
